// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: one pipeline register stage with a valid/ready handshake on both sides.
//
// With SKID=1 the stage has two entries, a head and a skid. in_ready depends only on
// registered state, so the stage breaks the ready timing path from downstream to upstream.
// With SKID=0 the stage has a single stall register. Its in_ready is combinational from
// out_ready.
//
// Both variants use the same state register. With SKID=0 an input handshake in ONE needs
// out_ready=1, so that handshake always comes with an output handshake, and the state
// never reaches TWO.
//
// The stage also keeps two saturating statistics counters: output handshakes, and stall
// cycles (out_valid=1 with out_ready=0).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream offers a word
//   in_ready   out  stage accepts a word this cycle
//   in_ctrl    in   upstream control word   [CTRL_W]
//   in_data    in   upstream payload        [DATA_W]
//   flush      in   synchronous kill of all held words (highest priority)
//   out_valid  out  head entry valid
//   out_ready  in   downstream accepts the head entry
//   out_ctrl   out  head control word, 0 when out_valid=0
//   out_data   out  head payload, 0 when out_valid=0
//   clr_cnt    in   synchronous clear of both counters
//   xfer_cnt   out  saturating count of output handshakes
//   stall_cnt  out  saturating count of stall cycles
//
// States:
//   state    | meaning
//   ---------+-----------------------------------------
//   ST_EMPTY | no word held, outputs zero
//   ST_ONE   | head entry valid and presented
//   ST_TWO   | head presented, skid entry also holds a word (SKID=1 only)

module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam bit             SKID_EN = (SKID != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              head_valid;

  logic in_hs;
  logic out_hs;
  logic stall_ev;

  // in_ready is gated with rst_n so that it reads 0 throughout reset and 1 as soon as
  // reset is released, without waiting for a clock edge.
  generate
    if (SKID_EN) begin : g_skid
      assign in_ready = rst_n & (state != ST_TWO);
    end else begin : g_stall
      assign in_ready = rst_n & (out_ready | ~head_valid);
    end
  endgenerate

  assign in_hs    = in_valid & in_ready;
  assign out_hs   = head_valid & out_ready;
  assign stall_ev = head_valid & ~out_ready;

  // The head registers are cleared whenever the stage empties. This keeps the outputs
  // zero while invalid and avoids an output mux.
  assign out_valid = head_valid;
  assign out_ctrl  = head_ctrl;
  assign out_data  = head_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      head_valid <= 1'b0;
      head_ctrl  <= '0;
      head_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      // Drops every held word, including any word arriving in this same cycle.
      state      <= ST_EMPTY;
      head_valid <= 1'b0;
      head_ctrl  <= '0;
      head_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_hs) begin
            state      <= ST_ONE;
            head_valid <= 1'b1;
            head_ctrl  <= in_ctrl;
            head_data  <= in_data;
          end
        end
        ST_ONE: begin
          if (in_hs && out_hs) begin
            head_ctrl <= in_ctrl;
            head_data <= in_data;
          end else if (in_hs && SKID_EN) begin
            state     <= ST_TWO;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (out_hs) begin
            state      <= ST_EMPTY;
            head_valid <= 1'b0;
            head_ctrl  <= '0;
            head_data  <= '0;
          end
        end
        ST_TWO: begin
          // in_ready is low in TWO, so no input handshake can happen here.
          if (out_hs) begin
            state     <= ST_ONE;
            head_ctrl <= skid_ctrl;
            head_data <= skid_data;
            skid_ctrl <= '0;
            skid_data <= '0;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          head_valid <= 1'b0;
          head_ctrl  <= '0;
          head_data  <= '0;
          skid_ctrl  <= '0;
          skid_data  <= '0;
        end
      endcase
    end
  end

  // Flush does not touch the counters. A handshake in the flush cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_hs && (xfer_cnt != CNT_MAX)) begin
        xfer_cnt <= xfer_cnt + CNT_ONE;
      end
      if (stall_ev && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_cnt = 1'b0;

  logic        ir1, ov1;
  logic [31:0] oc1, od1;
  logic [15:0] xc1, sc1;
  logic        ir0, ov0;
  logic [31:0] oc0, od0;
  logic [3:0]  xc0, sc0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(32), .CTRL_W(32), .SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
    .clr_cnt(clr_cnt), .xfer_cnt(xc1), .stall_cnt(sc1)
  );

  pipe_skid_reg #(.DATA_W(32), .CTRL_W(32), .SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
    .clr_cnt(clr_cnt), .xfer_cnt(xc0), .stall_cnt(sc0)
  );

  // Reference model: an in-order queue of {ctrl,data} words per instance, plus counters.
  logic [63:0] q1[$];
  logic [63:0] q0[$];
  int unsigned ex1 = 0, es1 = 0, ex0 = 0, es0 = 0;
  bit          m_ir1, m_ir0;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        s_ir1, s_ov1, s_ir0, s_ov0;
  logic [31:0] s_od1;
  bit          seen33 = 0;
  bit          hs0_en = 0;
  int          hs0_cnt = 0;

  typedef struct {
    bit          v;
    logic [31:0] c;
    bit          ordy;
    bit          fl;
    bit          e_ov;
    bit          e_ir;
    logic [31:0] e_d;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_pre();
    logic [63:0] h1, h0;
    m_ir1 = (q1.size() < 2);
    m_ir0 = out_ready || (q0.size() == 0);
    h1 = (q1.size() > 0) ? q1[0] : 64'd0;
    h0 = (q0.size() > 0) ? q0[0] : 64'd0;
    s_ir1 = ir1; s_ov1 = ov1; s_od1 = od1; s_ir0 = ir0; s_ov0 = ov0;
    if (ov1 && oc1 == 32'h33) seen33 = 1;
    if (hs0_en && ov0 && out_ready) hs0_cnt++;
    chk("skid.in_ready", {63'd0, ir1}, {63'd0, m_ir1});
    chk("skid.out_valid", {63'd0, ov1}, {63'd0, (q1.size() > 0)});
    chk("skid.out_ctrl", {32'd0, oc1}, {32'd0, h1[63:32]});
    chk("skid.out_data", {32'd0, od1}, {32'd0, h1[31:0]});
    chk("skid.xfer_cnt", {48'd0, xc1}, 64'(ex1));
    chk("skid.stall_cnt", {48'd0, sc1}, 64'(es1));
    chk("stall.in_ready", {63'd0, ir0}, {63'd0, m_ir0});
    chk("stall.out_valid", {63'd0, ov0}, {63'd0, (q0.size() > 0)});
    chk("stall.out_ctrl", {32'd0, oc0}, {32'd0, h0[63:32]});
    chk("stall.out_data", {32'd0, od0}, {32'd0, h0[31:0]});
    chk("stall.xfer_cnt", {60'd0, xc0}, 64'(ex0));
    chk("stall.stall_cnt", {60'd0, sc0}, 64'(es0));
  endtask

  task automatic model_edge();
    bit hi, ho, st;
    hi = in_valid && m_ir1; ho = (q1.size() > 0) && out_ready; st = (q1.size() > 0) && !out_ready;
    if (clr_cnt) begin ex1 = 0; es1 = 0; end
    else begin
      if (ho && ex1 < 65535) ex1++;
      if (st && es1 < 65535) es1++;
    end
    if (ho) void'(q1.pop_front());
    if (flush) q1.delete();
    else if (hi) q1.push_back({in_ctrl, in_data});
    hi = in_valid && m_ir0; ho = (q0.size() > 0) && out_ready; st = (q0.size() > 0) && !out_ready;
    if (clr_cnt) begin ex0 = 0; es0 = 0; end
    else begin
      if (ho && ex0 < 15) ex0++;
      if (st && es0 < 15) es0++;
    end
    if (ho) void'(q0.pop_front());
    if (flush) q0.delete();
    else if (hi) q0.push_back({in_ctrl, in_data});
  endtask

  task automatic cycle(input bit v, input logic [31:0] c, input logic [31:0] d,
                       input bit ordy, input bit fl, input bit clr);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; clr_cnt = clr;
    @(negedge clk);
    check_pre();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1011};
    tbl[2]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1011};
    tbl[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1011};
    tbl[4]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1022};
    tbl[5]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1044};
    tbl[8]  = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1044};
    tbl[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 32'h66, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 32'h77, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1066};
    tbl[12] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};

    // Reset: outputs zero, in_ready low, no handshake recognised while rst_n=0.
    in_valid = 1'b1; in_ctrl = 32'hDEAD; in_data = 32'hBEEF; out_ready = 1'b1;
    #1;
    chk("rst.skid.in_ready", {63'd0, ir1}, 64'd0);
    chk("rst.stall.in_ready", {63'd0, ir0}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.skid.out_valid", {63'd0, ov1}, 64'd0);
    chk("rst.skid.out_data", {32'd0, od1}, 64'd0);
    chk("rst.skid.out_ctrl", {32'd0, oc1}, 64'd0);
    chk("rst.skid.xfer_cnt", {48'd0, xc1}, 64'd0);
    chk("rst.stall.out_valid", {63'd0, ov0}, 64'd0);
    chk("rst.stall.stall_cnt", {60'd0, sc0}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release.skid.in_ready", {63'd0, ir1}, 64'd1);
    chk("rst_release.stall.in_ready", {63'd0, ir0}, 64'd1);
    @(posedge clk);
    #1;

    // Single word through the skid stage.
    cycle(1, 32'h00000C80, 32'h1234ABCD, 1, 0, 0);
    chk("single.out_valid", {63'd0, ov1}, 64'd1);
    chk("single.out_ctrl", {32'd0, oc1}, 64'h0C80);
    chk("single.out_data", {32'd0, od1}, 64'h1234ABCD);
    cycle(0, 0, 0, 1, 0, 0);
    chk("single.xfer_cnt", {48'd0, xc1}, 64'd1);
    chk("single.empty_after", {63'd0, ov1}, 64'd0);

    // Table: backpressure to TWO, in-order drain, flush with full stage, flush with handshakes.
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, tbl[i].c, tbl[i].c + 32'h1000, tbl[i].ordy, tbl[i].fl, 0);
      chk($sformatf("tbl[%0d].out_valid", i), {63'd0, s_ov1}, {63'd0, tbl[i].e_ov});
      chk($sformatf("tbl[%0d].in_ready", i), {63'd0, s_ir1}, {63'd0, tbl[i].e_ir});
      chk($sformatf("tbl[%0d].out_data", i), {32'd0, s_od1}, {32'd0, tbl[i].e_d});
    end
    chk("flush.word_c_never_seen", {63'd0, seen33}, 64'd0);

    // Stall register streaming: 8 words back to back.
    cycle(0, 0, 0, 1, 0, 1);
    hs0_cnt = 0;
    hs0_en = 1;
    for (int i = 0; i < 8; i++) cycle(1, 32'h100 + i, 32'hA000 + i, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    hs0_en = 0;
    chk("stream.stall.handshakes", 64'(hs0_cnt), 64'd8);
    chk("stream.stall.xfer_cnt", {60'd0, xc0}, 64'd8);
    cycle(1, 32'h200, 32'hB000, 1, 0, 0);
    cycle(1, 32'h201, 32'hB001, 0, 0, 0);
    chk("stream.bp1.in_ready", {63'd0, s_ir0}, 64'd0);
    cycle(1, 32'h201, 32'hB001, 0, 0, 0);
    chk("stream.bp2.in_ready", {63'd0, s_ir0}, 64'd0);
    cycle(1, 32'h201, 32'hB001, 1, 0, 0);
    chk("stream.resume.in_ready", {63'd0, s_ir0}, 64'd1);
    repeat (3) cycle(0, 0, 0, 1, 0, 0);

    // Counter saturation on the 4-bit instance, then clear.
    cycle(1, 32'h300, 32'hC000, 0, 0, 1);
    repeat (20) cycle(0, 0, 0, 0, 0, 0);
    chk("sat.stall.stall_cnt", {60'd0, sc0}, 64'd15);
    cycle(0, 0, 0, 0, 0, 1);
    chk("sat.clr.stall_cnt", {60'd0, sc0}, 64'd0);
    repeat (3) cycle(0, 0, 0, 1, 0, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) != 0,
            ($urandom % 25) == 0, ($urandom % 40) == 0);
    end
    repeat (3) cycle(0, 0, 0, 1, 0, 0);

    // Asynchronous reset while holding a word.
    cycle(1, 32'hA5, 32'h5A5A, 0, 0, 0);
    chk("arst.pre.out_valid", {63'd0, ov1}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.skid.out_valid", {63'd0, ov1}, 64'd0);
    chk("arst.skid.in_ready", {63'd0, ir1}, 64'd0);
    chk("arst.skid.out_data", {32'd0, od1}, 64'd0);
    chk("arst.stall.out_valid", {63'd0, ov0}, 64'd0);
    chk("arst.stall.in_ready", {63'd0, ir0}, 64'd0);
    chk("arst.skid.stall_cnt", {48'd0, sc1}, 64'd0);
    q1.delete(); q0.delete();
    ex1 = 0; es1 = 0; ex0 = 0; es0 = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1, 32'hB6, 32'h6B6B, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
